// File: rtl/avalon_arb_pkg.sv
// Shared types and the round-robin pick helper for the Avalon-MM initiator arbiter.
package avalon_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned MAX_IDW = $clog2(MAX_REQ);

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  // First set bit of req_vec at or after ptr, wrapping at num; returns ptr when none is set.
  function automatic int unsigned rr_pick(
    input logic [MAX_REQ-1:0] req_vec,
    input logic [MAX_IDW-1:0] ptr,
    input int unsigned        num
  );
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = 32'(ptr);
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= num) begin
        idx = idx - num;
      end
      if ((i < num) && !found && req_vec[idx[MAX_IDW-1:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/avalon_master_arbiter_rr_arbiter_core.sv
// Combinational round-robin selector: next owner index from the active vector and pointer.
module rr_arbiter_core
  import avalon_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = 1
) (
  input  logic [NUM_REQ-1:0] active,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [IDW-1:0]     pick,
  output logic               any_active
);

  logic [MAX_REQ-1:0] vec;
  logic [MAX_IDW-1:0] ptr_ext;

  always_comb begin
    vec                = '0;
    vec[NUM_REQ-1:0]   = active;
    ptr_ext            = '0;
    ptr_ext[IDW-1:0]   = rr_ptr;
    pick               = IDW'(rr_pick(vec, ptr_ext, NUM_REQ));
    any_active         = |active;
  end

endmodule

// File: rtl/avalon_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM initiator port among NUM_REQ requesters.
// Define ARB_LOCK_EN to let a requester keep the bus for up to LOCK_MAX back-to-back transfers.
module avalon_master_arbiter
  import avalon_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ  = 2,
  parameter  int unsigned AW       = 32,
  parameter  int unsigned DW       = 32,
  parameter  int unsigned LOCK_MAX = 4,
  localparam int unsigned IDW      = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_read,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_address,
  input  logic [NUM_REQ*DW-1:0] req_writedata,
  input  logic [NUM_REQ-1:0]    req_lock,
  output logic [NUM_REQ-1:0]    req_waitrequest,
  output logic [DW-1:0]         req_readdata,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [AW-1:0]         avm_address,
  output logic [DW-1:0]         avm_writedata,
  input  logic                  avm_waitrequest,
  input  logic [DW-1:0]         avm_readdata,
  output logic [IDW-1:0]        grant_id,
  output logic                  grant_valid
);

  arb_state_t           state, state_next;
  logic [IDW-1:0]       grant_next, rr_ptr, rr_ptr_next, pick, ptr_after;
  logic                 valid_next, any_active, done, release_now;
  logic [NUM_REQ-1:0]   active;
  logic [AW-1:0]        addr_arr [NUM_REQ];
  logic [DW-1:0]        data_arr [NUM_REQ];

`ifdef ARB_LOCK_EN
  localparam int unsigned LCW = $clog2(LOCK_MAX + 1);
  logic [LCW-1:0] lock_cnt, lock_cnt_next;
`else
  localparam int unsigned unused_lock_max = LOCK_MAX;
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  assign active = req_read | req_write;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_address[g*AW +: AW];
    assign data_arr[g] = req_writedata[g*DW +: DW];
  end

  rr_arbiter_core #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_core (
    .active     (active),
    .rr_ptr     (rr_ptr),
    .pick       (pick),
    .any_active (any_active)
  );

  assign ptr_after = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);

  // Owner's strobes go straight to the slave; write wins over an illegal read+write.
  always_comb begin
    avm_read        = 1'b0;
    avm_write       = 1'b0;
    avm_address     = '0;
    avm_writedata   = '0;
    req_waitrequest = '1;
    req_readdata    = avm_readdata;
    if (state == GRANT) begin
      avm_write                 = req_write[grant_id];
      avm_read                  = req_read[grant_id] & ~req_write[grant_id];
      avm_address               = addr_arr[grant_id];
      avm_writedata             = data_arr[grant_id];
      req_waitrequest[grant_id] = avm_waitrequest;
    end
  end

  always_comb begin
    state_next  = state;
    grant_next  = grant_id;
    valid_next  = grant_valid;
    rr_ptr_next = rr_ptr;
    release_now = 1'b0;
    done        = (avm_read | avm_write) & ~avm_waitrequest;
`ifdef ARB_LOCK_EN
    lock_cnt_next = lock_cnt;
`endif
    case (state)
      IDLE: begin
        if (any_active) begin
          grant_next = pick;
          valid_next = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT: begin
`ifdef ARB_LOCK_EN
        // A locked owner that drops its strobes parks the bus until its lock falls.
        if (done) begin
          if (req_lock[grant_id] && (lock_cnt < LCW'(LOCK_MAX - 1))) begin
            lock_cnt_next = lock_cnt + LCW'(1);
          end else begin
            release_now = 1'b1;
          end
        end else if (!(avm_read | avm_write) && !req_lock[grant_id]) begin
          release_now = 1'b1;
        end
`else
        release_now = done | ~(avm_read | avm_write);
`endif
        if (release_now) begin
          rr_ptr_next = ptr_after;
          valid_next  = 1'b0;
          state_next  = IDLE;
`ifdef ARB_LOCK_EN
          lock_cnt_next = '0;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      rr_ptr      <= '0;
`ifdef ARB_LOCK_EN
      lock_cnt    <= '0;
`endif
    end else begin
      state       <= state_next;
      grant_id    <= grant_next;
      grant_valid <= valid_next;
      rr_ptr      <= rr_ptr_next;
`ifdef ARB_LOCK_EN
      lock_cnt    <= lock_cnt_next;
`endif
    end
  end

endmodule
